// File: rtl/pong_paddle_ctrl_if.sv
// Signal bundle between the Pong round controller and its surroundings:
// button/ball/frame inputs in, paddle move pulses and round state out.
interface pong_paddle_ctrl_if;
    logic       frame_tick;
    logic       start;
    logic       stop;
    logic       point_scored;
    logic [1:0] btn_up;
    logic [1:0] btn_down;
    logic [8:0] ball_y;
    logic [8:0] paddle1_y;
    logic [1:0] paddle_up;
    logic [1:0] paddle_down;
    logic       paddle_reset;
    logic [1:0] state;

    modport master (
        output frame_tick, start, stop, point_scored, btn_up, btn_down, ball_y, paddle1_y,
        input  paddle_up, paddle_down, paddle_reset, state
    );

    modport slave (
        input  frame_tick, start, stop, point_scored, btn_up, btn_down, ball_y, paddle1_y,
        output paddle_up, paddle_down, paddle_reset, state
    );
endinterface

// File: rtl/pong_paddle_ctrl.sv
// Per-frame paddle movement scheduler and round sequencer for Pong.
// Define PADDLE_AI_EN to drive paddle 1 from a ball-tracking AI instead of its buttons.
module pong_paddle_ctrl #(
    parameter int unsigned STEP        = 2,
    parameter int unsigned HOLD_FRAMES = 60,
    parameter int unsigned HEIGTH      = 20,
    parameter int unsigned DEADBAND    = 2
) (
    input logic              clock,
    input logic              reset,
    pong_paddle_ctrl_if.slave bus
);
    localparam int unsigned BURST_W = 4;
    localparam int unsigned HOLD_W  = 8;
    localparam int unsigned AI_W    = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CENTER = 2'd1,
        PLAY   = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic [1:0]           dir_up_q, dir_up_d, dir_dn_q, dir_dn_d;
    logic [1:0]           up_q, up_d, dn_q, dn_d;
    logic                 prst_q, prst_d;
    logic [1:0]           up_s1, up_s2, dn_s1, dn_s2;
    logic [1:0]           new_up, new_dn;

    // Two-flop synchronizers for the raw buttons
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            up_s1 <= '0;
            up_s2 <= '0;
            dn_s1 <= '0;
            dn_s2 <= '0;
        end else begin
            up_s1 <= bus.btn_up;
            up_s2 <= up_s1;
            dn_s1 <= bus.btn_down;
            dn_s2 <= dn_s1;
        end
    end

    assign new_up[0] = up_s2[0] & ~dn_s2[0];
    assign new_dn[0] = dn_s2[0] & ~up_s2[0];

`ifdef PADDLE_AI_EN
    logic [AI_W-1:0] centre;
    logic            unused_btn1;

    // Track the ball with paddle 1's centre, ignoring small offsets
    assign centre      = AI_W'(bus.paddle1_y) + AI_W'(HEIGTH / 2);
    assign new_up[1]   = AI_W'(bus.ball_y) > (centre + AI_W'(DEADBAND));
    assign new_dn[1]   = (AI_W'(bus.ball_y) + AI_W'(DEADBAND)) < centre;
    assign unused_btn1 = up_s2[1] ^ dn_s2[1];
`else
    logic unused_ai;

    assign new_up[1] = up_s2[1] & ~dn_s2[1];
    assign new_dn[1] = dn_s2[1] & ~up_s2[1];
    assign unused_ai = ^{bus.ball_y, bus.paddle1_y, AI_W'(HEIGTH), AI_W'(DEADBAND)};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            hold_q   <= '0;
            dir_up_q <= '0;
            dir_dn_q <= '0;
            up_q     <= '0;
            dn_q     <= '0;
            prst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            hold_q   <= hold_d;
            dir_up_q <= dir_up_d;
            dir_dn_q <= dir_dn_d;
            up_q     <= up_d;
            dn_q     <= dn_d;
            prst_q   <= prst_d;
        end
    end

    // Round sequencing and burst generation; stop overrides everything
    always_comb begin
        state_d  = state_q;
        burst_d  = '0;
        hold_d   = hold_q;
        dir_up_d = dir_up_q;
        dir_dn_d = dir_dn_q;
        up_d     = '0;
        dn_d     = '0;
        prst_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = CENTER;
            end
            CENTER: begin
                state_d = PLAY;
            end
            PLAY: begin
                if (bus.point_scored) begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(HOLD_FRAMES);
                end else begin
                    if (burst_q != '0) begin
                        up_d    = dir_up_q;
                        dn_d    = dir_dn_q;
                        burst_d = burst_q - BURST_W'(1);
                    end
                    // A new frame restarts the burst without a gap
                    if (bus.frame_tick) begin
                        burst_d  = BURST_W'(STEP);
                        dir_up_d = new_up;
                        dir_dn_d = new_dn;
                    end
                end
            end
            HOLD: begin
                if (bus.frame_tick) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d = CENTER;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.stop) begin
            state_d = IDLE;
            burst_d = '0;
            hold_d  = '0;
            up_d    = '0;
            dn_d    = '0;
        end

        prst_d = (state_d == CENTER);
    end

    assign bus.paddle_up    = up_q;
    assign bus.paddle_down  = dn_q;
    assign bus.paddle_reset = prst_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Directed bench for pong_paddle_ctrl (STEP=2, HOLD_FRAMES=3); AI steps run when PADDLE_AI_EN is defined.
module tb_pong_paddle_ctrl;
    logic clock;
    logic reset;
    int   checks = 0;
    int   errors = 0;

`ifdef PADDLE_AI_EN
    localparam logic [1:0] BTN_MASK = 2'b01;
`else
    localparam logic [1:0] BTN_MASK = 2'b11;
`endif

    pong_paddle_ctrl_if bus ();

    pong_paddle_ctrl #(
        .STEP(2), .HOLD_FRAMES(3), .HEIGTH(20), .DEADBAND(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] up, input logic [1:0] dn);
        check({tag, "_up"}, 32'(bus.paddle_up), 32'(up));
        check({tag, "_dn"}, 32'(bus.paddle_down), 32'(dn));
    endtask

    task automatic start_round();
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        step(1);
    endtask

    initial begin
        reset            = 1'b0;
        bus.frame_tick   = 1'b0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.point_scored = 1'b0;
        bus.btn_up       = 2'b00;
        bus.btn_down     = 2'b00;
        bus.ball_y       = 9'd110;
        bus.paddle1_y    = 9'd100;
        step(3);
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_prst", 32'(bus.paddle_reset), 32'd0);
        check_out("rst", 2'b00, 2'b00);
        reset = 1'b1;
        step(2);

        // start: one CENTER cycle with paddle_reset, then PLAY
        bus.start = 1'b1;
        step(1);
        bus.start = 1'b0;
        check("start_state_center", 32'(bus.state), 32'd1);
        check("start_prst_hi", 32'(bus.paddle_reset), 32'd1);
        step(1);
        check("start_state_play", 32'(bus.state), 32'd2);
        check("start_prst_lo", 32'(bus.paddle_reset), 32'd0);

        // burst: paddle 0 up, paddle 1 down, two pulses
        bus.btn_up   = 2'b01;
        bus.btn_down = 2'b10;
        step(3);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        check_out("burst_load", 2'b00, 2'b00);
        step(1);
        check_out("burst_p1", 2'b01, 2'b10 & BRN(BTN_MASK));
        step(1);
        check_out("burst_p2", 2'b01, 2'b10 & BRN(BTN_MASK));
        step(1);
        check_out("burst_end", 2'b00, 2'b00);

        // both buttons on paddle 0: no movement
        bus.btn_up   = 2'b01;
        bus.btn_down = 2'b01;
        step(3);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(1);
        check_out("conflict_p1", 2'b00, 2'b00);
        step(1);
        check_out("conflict_p2", 2'b00, 2'b00);

        // second frame one cycle into the burst: STEP+1 contiguous pulses
        bus.btn_up   = 2'b11;
        bus.btn_down = 2'b00;
        step(3);
        bus.frame_tick = 1'b1;
        step(1);
        step(1);
        bus.frame_tick = 1'b0;
        check_out("restart_p1", 2'b11 & BTN_MASK, 2'b00);
        step(1);
        check_out("restart_p2", 2'b11 & BTN_MASK, 2'b00);
        step(1);
        check_out("restart_p3", 2'b11 & BTN_MASK, 2'b00);
        step(1);
        check_out("restart_end", 2'b00, 2'b00);

        // point with frame_tick: point wins, then hold for 3 frames
        bus.frame_tick   = 1'b1;
        bus.point_scored = 1'b1;
        step(1);
        bus.frame_tick   = 1'b0;
        bus.point_scored = 1'b0;
        check("point_state", 32'(bus.state), 32'd3);
        check_out("point_now", 2'b00, 2'b00);
        step(1);
        check_out("point_next", 2'b00, 2'b00);
        for (int f = 0; f < 2; f++) begin
            bus.frame_tick = 1'b1;
            step(1);
            bus.frame_tick = 1'b0;
            step(1);
            check("hold_state", 32'(bus.state), 32'd3);
        end
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        check("hold_exit_state", 32'(bus.state), 32'd1);
        check("hold_exit_prst", 32'(bus.paddle_reset), 32'd1);
        step(1);
        check("hold_play_state", 32'(bus.state), 32'd2);
        check("hold_play_prst", 32'(bus.paddle_reset), 32'd0);

        // stop during HOLD
        bus.point_scored = 1'b1;
        step(1);
        bus.point_scored = 1'b0;
        check("stop_pre_state", 32'(bus.state), 32'd3);
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
        check("stop_state", 32'(bus.state), 32'd0);

        // point and frame ignored in IDLE
        bus.point_scored = 1'b1;
        bus.frame_tick   = 1'b1;
        step(1);
        bus.point_scored = 1'b0;
        bus.frame_tick   = 1'b0;
        check("idle_state", 32'(bus.state), 32'd0);
        step(1);
        check("idle_state2", 32'(bus.state), 32'd0);
        check("idle_prst", 32'(bus.paddle_reset), 32'd0);
        check_out("idle", 2'b00, 2'b00);

        // asynchronous reset mid-burst
        start_round();
        check("rst2_pre_state", 32'(bus.state), 32'd2);
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(1);
        check_out("rst2_pre", 2'b11 & BTN_MASK, 2'b00);
        #2;
        reset = 1'b0;
        #1;
        check("rst2_state", 32'(bus.state), 32'd0);
        check_out("rst2", 2'b00, 2'b00);
        step(1);
        reset = 1'b1;
        bus.btn_up = 2'b00;
        step(1);

`ifdef PADDLE_AI_EN
        // AI tracking for paddle 1 (centre 110, deadband 2)
        start_round();
        bus.paddle1_y = 9'd100;
        bus.ball_y    = 9'd120;
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(1);
        check_out("ai_up", 2'b10, 2'b00);
        step(2);
        bus.ball_y     = 9'd111;
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(1);
        check_out("ai_none", 2'b00, 2'b00);
        step(2);
        bus.ball_y     = 9'd100;
        bus.frame_tick = 1'b1;
        step(1);
        bus.frame_tick = 1'b0;
        step(1);
        check_out("ai_down", 2'b00, 2'b10);
        step(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [1:0] BRN(input logic [1:0] m);
        return m;
    endfunction
endmodule
